// File: rtl/des_region_scheduler_if.sv
// Shared command bus between the region scheduler (master) and the DES core array (slave).
// Handshake: master drives core_cmd/core_data_* with core_cmd_vld[i]=1 and holds them stable until core_cmd_rd[i]=1,
// then drops core_cmd_vld[i]; no core_cmd_vld bit rises again until every core_cmd_rd bit is back to 0.
interface des_region_scheduler_if #(
  parameter int NUM_CORES = 4
);
  logic [31:0]             core_cmd;
  logic [31:0]             core_data_hi;
  logic [31:0]             core_data_lo;
  logic [NUM_CORES-1:0]    core_cmd_vld;
  logic [NUM_CORES-1:0]    core_cmd_rd;
  logic [NUM_CORES-1:0]    core_done;
  logic [64*NUM_CORES-1:0] core_counter;

  modport master (
    output core_cmd, core_data_hi, core_data_lo, core_cmd_vld,
    input  core_cmd_rd, core_done, core_counter
  );

  modport slave (
    input  core_cmd, core_data_hi, core_data_lo, core_cmd_vld,
    output core_cmd_rd, core_done, core_counter
  );
endinterface

// File: rtl/des_region_scheduler.sv
// Hands consecutive seed regions to free DES cores over the shared command bus and sums their 64-bit counters.
// Optional feature macro DES_SCHED_PERF_EN adds perf_cycles, counting every cycle of the job while busy.
module des_region_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int REGION_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [63:0]         base_seed,
  input  logic [63:0]         poly,
  input  logic [REGION_W-1:0] num_regions,
  output logic                busy,
  output logic                done,
  output logic [63:0]         total_count,
  output logic                overflow,
  output logic [REGION_W-1:0] regions_done,
  output logic [2:0]          dbg_state,
  des_region_scheduler_if.master bus
`ifdef DES_SCHED_PERF_EN
  ,
  output logic [63:0]         perf_cycles
`endif
);
  localparam int IDXW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [31:0] CMD_SEED    = 32'd1;
  localparam logic [31:0] CMD_POLY    = 32'd2;
  localparam logic [31:0] CMD_START   = 32'd3;
  localparam logic [31:0] CMD_RESTART = 32'd5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SCAN    = 3'd1,
    S_ISSUE   = 3'd2,
    S_RELEASE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CORE_FRESH = 2'd0,
    CORE_RUN   = 2'd1,
    CORE_FREE  = 2'd2
  } core_st_t;

  state_t              state;
  core_st_t            core_st [NUM_CORES];
  logic [63:0]         base_q;
  logic [63:0]         poly_q;
  logic [REGION_W-1:0] nreg_q;
  logic [REGION_W-1:0] next_region;
  logic [IDXW-1:0]     last_served;
  logic [IDXW-1:0]     cur_core;

  logic                col_found, seed_found;
  logic [IDXW-1:0]     col_idx, seed_idx, sel_idx;
  logic [NUM_CORES-1:0] sel_onehot;
  logic [63:0]         col_counter;
  logic [64:0]         acc_sum;
  logic [63:0]         seed_next;
  logic                rd_idle, more_regions;

  assign rd_idle      = ~|bus.core_cmd_rd;
  assign more_regions = next_region < nreg_q;
  assign seed_next    = base_q + 64'(next_region);
  assign dbg_state    = state;

  // Round-robin search starting after last_served; collecting a finished core outranks seeding a free one.
  always_comb begin
    int              cand;
    logic [IDXW-1:0] ci;
    cand       = 0;
    ci         = '0;
    col_found  = 1'b0;
    seed_found = 1'b0;
    col_idx    = '0;
    seed_idx   = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = int'(last_served) + k;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      ci = IDXW'(cand);
      if (!col_found && core_st[ci] == CORE_RUN && bus.core_done[ci]) begin
        col_found = 1'b1;
        col_idx   = ci;
      end
      if (!seed_found && core_st[ci] != CORE_RUN && more_regions) begin
        seed_found = 1'b1;
        seed_idx   = ci;
      end
    end
    sel_idx             = col_found ? col_idx : seed_idx;
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
    col_counter         = bus.core_counter[64*col_idx +: 64];
    acc_sum             = {1'b0, total_count} + {1'b0, col_counter};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      total_count      <= '0;
      overflow         <= 1'b0;
      regions_done     <= '0;
      base_q           <= '0;
      poly_q           <= '0;
      nreg_q           <= '0;
      next_region      <= '0;
      last_served      <= IDXW'(NUM_CORES - 1);
      cur_core         <= '0;
      bus.core_cmd     <= '0;
      bus.core_data_hi <= '0;
      bus.core_data_lo <= '0;
      bus.core_cmd_vld <= '0;
      for (int i = 0; i < NUM_CORES; i++) core_st[i] <= CORE_FRESH;
`ifdef DES_SCHED_PERF_EN
      perf_cycles      <= '0;
`endif
    end else begin
`ifdef DES_SCHED_PERF_EN
      if (busy) perf_cycles <= perf_cycles + 64'd1;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q       <= base_seed;
            poly_q       <= poly;
            nreg_q       <= num_regions;
            next_region  <= '0;
            total_count  <= '0;
            overflow     <= 1'b0;
            regions_done <= '0;
            done         <= 1'b0;
            busy         <= 1'b1;
            state        <= (num_regions == '0) ? S_FINISH : S_SCAN;
`ifdef DES_SCHED_PERF_EN
            perf_cycles  <= '0;
`endif
          end
        end
        S_SCAN: begin
          if (regions_done == nreg_q) begin
            state <= S_FINISH;
          end else if (rd_idle && col_found) begin
            total_count      <= acc_sum[63:0];
            overflow         <= overflow | acc_sum[64];
            regions_done     <= regions_done + REGION_W'(1);
            core_st[col_idx] <= CORE_FREE;
            last_served      <= col_idx;
            cur_core         <= col_idx;
            bus.core_cmd     <= CMD_RESTART;
            bus.core_data_hi <= '0;
            bus.core_data_lo <= '0;
            bus.core_cmd_vld <= sel_onehot;
            state            <= S_ISSUE;
          end else if (rd_idle && seed_found) begin
            // Marked RUN now so no other pick can land on it while its SEED/POLY/START sequence is in flight.
            core_st[seed_idx] <= CORE_RUN;
            next_region       <= next_region + REGION_W'(1);
            last_served       <= seed_idx;
            cur_core          <= seed_idx;
            bus.core_cmd      <= CMD_SEED;
            bus.core_data_hi  <= seed_next[63:32];
            bus.core_data_lo  <= seed_next[31:0];
            bus.core_cmd_vld  <= sel_onehot;
            state             <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.core_cmd_rd[cur_core]) begin
            bus.core_cmd_vld <= '0;
            state            <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (rd_idle) begin
            if (bus.core_cmd == CMD_SEED) begin
              bus.core_cmd              <= CMD_POLY;
              bus.core_data_hi          <= poly_q[63:32];
              bus.core_data_lo          <= poly_q[31:0];
              bus.core_cmd_vld[cur_core] <= 1'b1;
              state                     <= S_ISSUE;
            end else if (bus.core_cmd == CMD_POLY) begin
              bus.core_cmd              <= CMD_START;
              bus.core_data_hi          <= '0;
              bus.core_data_lo          <= '0;
              bus.core_cmd_vld[cur_core] <= 1'b1;
              state                     <= S_ISSUE;
            end else begin
              state <= S_SCAN;
            end
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des_region_scheduler.sv
// Bench for des_region_scheduler: behavioural DES core models on the shared bus and a region-sum reference model.
module tb_des_region_scheduler;
  localparam int NC = 4;
  localparam int RW = 32;
  localparam logic [31:0] C_SEED    = 32'd1;
  localparam logic [31:0] C_POLY    = 32'd2;
  localparam logic [31:0] C_START   = 32'd3;
  localparam logic [31:0] C_RESTART = 32'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [63:0]   base_seed = '0;
  logic [63:0]   poly = '0;
  logic [RW-1:0] num_regions = '0;
  logic          busy, done, overflow;
  logic [63:0]   total_count;
  logic [RW-1:0] regions_done;
  logic [2:0]    dbg_state;
`ifdef DES_SCHED_PERF_EN
  logic [63:0]   perf_cycles;
`endif

  des_region_scheduler_if #(.NUM_CORES(NC)) bus ();

  des_region_scheduler #(.NUM_CORES(NC), .REGION_W(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_seed    (base_seed),
    .poly         (poly),
    .num_regions  (num_regions),
    .busy         (busy),
    .done         (done),
    .total_count  (total_count),
    .overflow     (overflow),
    .regions_done (regions_done),
    .dbg_state    (dbg_state),
    .bus          (bus)
`ifdef DES_SCHED_PERF_EN
    ,
    .perf_cycles  (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] region_val [64];
  logic        hold_done = 1'b0;
  int          max_delay = 4;

  // Core models: 2-flop sync of cmd_vld, registered ack, done after a random delay, level done until RESTART.
  logic [NC-1:0]    s1, s2, rd_r, cdone, running;
  logic [63:0]      seed_m [NC];
  logic [63:0]      cnt_m [NC];
  int               dly [NC];
  logic [63:0]      obs_q[$];
  int               log_core_q[$];
  int               log_cmd_q[$];
  int               proto_err = 0;
  int               proto_err_n = 0;
  int               vld_seen = 0;
  logic [64*NC-1:0] counter_flat;

  assign bus.core_cmd_rd  = rd_r;
  assign bus.core_done    = cdone & ~{NC{hold_done}};
  assign bus.core_counter = counter_flat;

  always_comb begin
    counter_flat = '0;
    for (int i = 0; i < NC; i++) counter_flat[64*i +: 64] = cnt_m[i];
  end

  function automatic logic [63:0] region_lookup(input logic [63:0] s);
    logic [63:0] d;
    d = s - base_seed;
    return region_val[d[5:0]];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (rst) begin
        s1[i] <= 1'b0; s2[i] <= 1'b0; rd_r[i] <= 1'b0;
        cdone[i] <= 1'b0; running[i] <= 1'b0;
        seed_m[i] <= '0; cnt_m[i] <= '0; dly[i] <= 0;
      end else begin
        s1[i]   <= bus.core_cmd_vld[i];
        s2[i]   <= s1[i];
        rd_r[i] <= s2[i];
        if (s2[i] && !rd_r[i]) begin
          log_core_q.push_back(i);
          log_cmd_q.push_back(int'(bus.core_cmd));
          case (bus.core_cmd)
            C_SEED: begin
              seed_m[i] <= {bus.core_data_hi, bus.core_data_lo};
              obs_q.push_back({bus.core_data_hi, bus.core_data_lo});
            end
            C_POLY: if ({bus.core_data_hi, bus.core_data_lo} != poly) proto_err <= proto_err + 1;
            C_START: begin
              running[i] <= 1'b1;
              dly[i]     <= int'($urandom_range(max_delay, 0));
            end
            C_RESTART: begin
              cdone[i] <= 1'b0;
              cnt_m[i] <= '0;
            end
            default: proto_err <= proto_err + 1;
          endcase
        end else if (running[i]) begin
          if (dly[i] == 0) begin
            running[i] <= 1'b0;
            cdone[i]   <= 1'b1;
            cnt_m[i]   <= region_lookup(seed_m[i]);
          end else begin
            dly[i] <= dly[i] - 1;
          end
        end
      end
    end
  end

  // Bus protocol watch: one-hot valid, no valid rise while any ack high, stable data while valid.
  logic [NC-1:0] vld_last = '0;
  logic [95:0]   bus_last = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (((bus.core_cmd_vld & ~vld_last) != '0) && (bus.core_cmd_rd != '0)) proto_err_n <= proto_err_n + 1;
      else if (!$onehot0(bus.core_cmd_vld)) proto_err_n <= proto_err_n + 1;
      else if (((vld_last & bus.core_cmd_vld) != '0) &&
               ({bus.core_cmd, bus.core_data_hi, bus.core_data_lo} != bus_last)) proto_err_n <= proto_err_n + 1;
    end
    if (bus.core_cmd_vld != '0) vld_seen <= vld_seen + 1;
    vld_last <= bus.core_cmd_vld;
    bus_last <= {bus.core_cmd, bus.core_data_hi, bus.core_data_lo};
  end

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check64({tag, "_done_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic run_job(input string tag, input logic [63:0] b, input logic [63:0] p,
                         input int nreg, input int maxd, input bit fill, input bit hold);
    logic [63:0]  exp_q[$];
    logic [63:0]  got_q[$];
    logic [127:0] sum;
    int           obs0, perr0, perrn0, c;
    max_delay = maxd;
    if (fill) for (int r = 0; r < nreg; r++) region_val[r] = {$urandom, $urandom};
    sum = '0;
    for (int r = 0; r < nreg; r++) begin
      exp_q.push_back(b + 64'(r));
      sum = sum + 128'(region_val[r]);
    end
    obs0   = obs_q.size();
    perr0  = proto_err;
    perrn0 = proto_err_n;
    hold_done = hold;
    @(negedge clk);
    base_seed = b; poly = p; num_regions = RW'(nreg); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check64({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    check64({tag, "_done_cleared"}, 64'(done), 64'd0);
    if (hold) begin
      c = 0;
      while (cdone != '1 && c < 3000) begin
        @(negedge clk);
        c++;
      end
      check64({tag, "_all_cores_ready"}, 64'(cdone), 64'(4'hF));
      repeat (3) @(negedge clk);
      hold_done = 1'b0;
    end
    wait_done(tag);
    check64({tag, "_busy_end"}, 64'(busy), 64'd0);
    check64({tag, "_total"}, total_count, sum[63:0]);
    check64({tag, "_overflow"}, 64'(overflow), 64'(sum[127:64] != '0));
    check64({tag, "_regions_done"}, 64'(regions_done), 64'(nreg));
    check64({tag, "_state_idle"}, 64'(dbg_state), 64'd0);
    for (int k = obs0; k < obs_q.size(); k++) got_q.push_back(obs_q[k]);
    got_q.sort();
    exp_q.sort();
    check64({tag, "_seed_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) check64({tag, "_seed"}, got_q[k], exp_q[k]);
    check64({tag, "_proto"}, 64'(proto_err - perr0), 64'd0);
    check64({tag, "_bus_proto"}, 64'(proto_err_n - perrn0), 64'd0);
    check64({tag, "_cores_reinit"}, 64'(cdone | running), 64'd0);
  endtask

  initial begin
    int log0, nseed, seed_core, last_start, nrs, v0;
    logic [63:0] rb;

    repeat (3) @(negedge clk);
    check64("rst_busy", 64'(busy), 64'd0);
    check64("rst_done", 64'(done), 64'd0);
    check64("rst_total", total_count, 64'd0);
    check64("rst_overflow", 64'(overflow), 64'd0);
    check64("rst_regions_done", 64'(regions_done), 64'd0);
    check64("rst_vld", 64'(bus.core_cmd_vld), 64'd0);
    check64("rst_cmd", 64'(bus.core_cmd), 64'd0);
    check64("rst_data", {bus.core_data_hi, bus.core_data_lo}, 64'd0);
    check64("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // One region: only core0 is seeded after reset.
    region_val[0] = 64'h10;
    log0 = log_core_q.size();
    run_job("one_region", 64'h0, 64'hB0B0_1234_5678_9ABC, 1, 2, 1'b0, 1'b0);
    check64("one_region_total16", total_count, 64'h10);
    nseed = 0; seed_core = -1;
    for (int k = log0; k < log_core_q.size(); k++)
      if (log_cmd_q[k] == int'(C_SEED)) begin nseed++; seed_core = log_core_q[k]; end
    check64("one_region_nseed", 64'(nseed), 64'd1);
    check64("one_region_core0", 64'(seed_core), 64'd0);

    // Ten regions from 0x100 with counters region+1.
    for (int r = 0; r < 10; r++) region_val[r] = 64'(r + 1);
    run_job("ten_regions", 64'h100, 64'h0000_0000_8000_000D, 10, 5, 1'b0, 1'b0);
    check64("ten_regions_total55", total_count, 64'd55);

    // Zero regions: done two cycles after start, bus untouched.
    v0 = vld_seen;
    @(negedge clk);
    num_regions = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check64("zero_busy_c1", 64'(busy), 64'd1);
    check64("zero_done_c1", 64'(done), 64'd0);
    @(negedge clk);
    check64("zero_done_c2", 64'(done), 64'd1);
    check64("zero_busy_c2", 64'(busy), 64'd0);
    check64("zero_total", total_count, 64'd0);
    check64("zero_no_vld", 64'(vld_seen - v0), 64'd0);
`ifdef DES_SCHED_PERF_EN
    check64("zero_perf", perf_cycles, 64'd1);
`endif

    // All four cores raise done together: collected in round-robin order, nothing lost.
    log0 = log_core_q.size();
    run_job("tie", 64'h5000, 64'h1111_2222_3333_4444, 4, 0, 1'b1, 1'b1);
    last_start = -1; nrs = 0;
    for (int k = log0; k < log_core_q.size(); k++) begin
      if (log_cmd_q[k] == int'(C_START) && nrs == 0) last_start = log_core_q[k];
      if (log_cmd_q[k] == int'(C_RESTART)) begin
        check64("tie_rr_order", 64'(log_core_q[k]), 64'((last_start + 1 + nrs) % NC));
        nrs++;
      end
    end
    check64("tie_collects", 64'(nrs), 64'd4);

    // Carry out of the 64-bit total.
    region_val[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    region_val[1] = 64'd2;
    run_job("ovf", 64'h77, 64'h5, 2, 3, 1'b0, 1'b0);
    check64("ovf_total1", total_count, 64'd1);
    check64("ovf_flag1", 64'(overflow), 64'd1);

    // Reset in the middle of a job, then a clean job.
    for (int r = 0; r < 10; r++) region_val[r] = {$urandom, $urandom};
    @(negedge clk);
    base_seed = 64'h9000; poly = 64'hABCD; num_regions = RW'(10); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check64("midrst_busy", 64'(busy), 64'd0);
    check64("midrst_done", 64'(done), 64'd0);
    check64("midrst_total", total_count, 64'd0);
    check64("midrst_regions", 64'(regions_done), 64'd0);
    check64("midrst_vld", 64'(bus.core_cmd_vld), 64'd0);
    check64("midrst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    run_job("after_rst", 64'h9000, 64'hABCD, 10, 4, 1'b1, 1'b0);

    // Randomised jobs, the first one wrapping the 64-bit seed.
    for (int j = 0; j < 6; j++) begin
      rb = (j == 0) ? 64'hFFFF_FFFF_FFFF_FFFD : {$urandom, $urandom};
      run_job("rand", rb, {$urandom, $urandom}, int'($urandom_range(20, 1)),
              int'($urandom_range(8, 0)), 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
